// File: rtl/rlc_game_sysid_check.sv
// System ID / build timestamp checker: reads two words over Avalon-MM and
// compares them against the expected values, with a per-read stall timeout.
module rlc_game_sysid_check #(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1495887352,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        busy,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    // state | meaning
    // IDLE  | waiting for start (or the one automatic check after reset)
    // RD_ID | reading word 0, the system ID
    // RD_TS | reading word 1, the build timestamp
    // CHECK | comparing captured words against the expected values
    // FIN   | done asserted for one cycle before returning to IDLE
    typedef enum logic [2:0] {IDLE, RD_ID, RD_TS, CHECK, FIN} state_t;

    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic        auto_q;
    logic        read_q, read_d;
    logic        addr_q, addr_d;
    logic [15:0] stall_q, stall_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic        timeout_q, timeout_d;
    logic [31:0] id_q, id_d;
    logic [31:0] ts_q, ts_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            auto_q    <= AUTO_START;
            read_q    <= 1'b0;
            addr_q    <= 1'b0;
            stall_q   <= 16'd0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            id_q      <= 32'd0;
            ts_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            auto_q    <= 1'b0;
            read_q    <= read_d;
            addr_q    <= addr_d;
            stall_q   <= stall_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            timeout_q <= timeout_d;
            id_q      <= id_d;
            ts_q      <= ts_d;
        end
    end

    // Bus strobes are computed from the next state so they come straight off flops.
    always_comb begin
        state_d   = state_q;
        read_d    = 1'b0;
        addr_d    = 1'b0;
        stall_d   = stall_q;
        done_d    = done_q;
        pass_d    = pass_q;
        timeout_d = timeout_q;
        id_d      = id_q;
        ts_d      = ts_q;
        case (state_q)
            IDLE: begin
                if (start || auto_q) begin
                    state_d   = RD_ID;
                    read_d    = 1'b1;
                    stall_d   = 16'd0;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            RD_ID, RD_TS: begin
                if (!avm_waitrequest) begin
                    stall_d = 16'd0;
                    if (state_q == RD_ID) begin
                        id_d    = avm_readdata;
                        state_d = RD_TS;
                        read_d  = 1'b1;
                        addr_d  = 1'b1;
                    end else begin
                        ts_d    = avm_readdata;
                        state_d = CHECK;
                    end
                end else begin
                    stall_d = stall_q + 16'd1;
                    if (stall_d == TIMEOUT_LIM) begin
                        state_d   = FIN;
                        timeout_d = 1'b1;
                        pass_d    = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        read_d = 1'b1;
                        addr_d = (state_q == RD_TS);
                    end
                end
            end
            CHECK: begin
                pass_d  = (id_q == EXPECTED_ID) && (ts_q == EXPECTED_TS);
                done_d  = 1'b1;
                state_d = FIN;
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy        = (state_q != IDLE);
    assign avm_read    = read_q;
    assign avm_address = addr_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign timeout     = timeout_q;
    assign id_value    = id_q;
    assign ts_value    = ts_q;

endmodule

// File: tb/tb_rlc_game_sysid_check.sv
// Randomized scoreboard bench for rlc_game_sysid_check with a stalling slave model.
module tb_rlc_game_sysid_check;

    localparam int          TO  = 4;
    localparam logic [31:0] EID = 32'd0;
    localparam logic [31:0] ETS = 32'd1495887352;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, avm_address, avm_read;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata;
    logic        done, pass, timeout;
    logic [31:0] id_value, ts_value;

    always #5 clock = ~clock;

    rlc_game_sysid_check #(
        .EXPECTED_ID(EID), .EXPECTED_TS(ETS), .TIMEOUT_CYCLES(TO), .AUTO_START(1'b1)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .busy(busy),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .done(done), .pass(pass), .timeout(timeout),
        .id_value(id_value), .ts_value(ts_value)
    );

    typedef struct {
        int          lat;
        logic        pass;
        logic        tmo;
        logic [31:0] id;
        logic [31:0] ts;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem0 = 32'd0, mem1 = ETS;
    int          plan_id = 0, plan_ts = 0;
    logic [31:0] m_id = 32'd0, m_ts = 32'd0;

    assign avm_readdata = avm_address ? mem1 : mem0;

    // Reference: outcome of one check from the slave contents and stall plans.
    task automatic expect_check();
        exp_t e;
        if (plan_id >= TO) begin
            e = '{TO + 1, 1'b0, 1'b1, m_id, m_ts};
        end else if (plan_ts >= TO) begin
            m_id = mem0;
            e = '{plan_id + TO + 2, 1'b0, 1'b1, m_id, m_ts};
        end else begin
            m_id = mem0;
            m_ts = mem1;
            e = '{plan_id + plan_ts + 4, (m_id == EID) && (m_ts == ETS), 1'b0, m_id, m_ts};
        end
        exp_q.push_back(e);
    endtask

    // Slave: stall each read for its planned number of cycles.
    initial begin
        int scnt;
        int p;
        scnt = 0;
        forever begin
            @(posedge clock);
            #1;
            if (avm_read) begin
                p = avm_address ? plan_ts : plan_id;
                if (scnt < p) begin
                    avm_waitrequest = 1'b1;
                    scnt++;
                end else begin
                    avm_waitrequest = 1'b0;
                    scnt = 0;
                end
            end else begin
                avm_waitrequest = 1'b0;
                scnt = 0;
            end
        end
    end

    // Monitor: bus stability under stall, and scoreboard compare on each done rise.
    initial begin
        logic pr, pw, pa, pbusy, pdone;
        int   run, cyc;
        exp_t e;
        pr = 0; pw = 0; pa = 0; pbusy = 0; pdone = 0; run = 0; cyc = 0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                pr = 0; pw = 0; pa = 0; pbusy = 0; pdone = 0; run = 0; cyc = 0;
            end else begin
                if (pr && pw && run < TO) begin
                    checks++;
                    if (!(avm_read && avm_address == pa)) begin
                        errors++;
                        $display("FAIL stall_hold: read=%0b addr=%0b, required read=1 addr=%0b",
                                 avm_read, avm_address, pa);
                    end
                end
                if (avm_read && avm_waitrequest) run++; else run = 0;
                pr = avm_read; pw = avm_waitrequest; pa = avm_address;
                if (busy && !pbusy) cyc = 1;
                else if (busy) cyc++;
                if (done && !pdone) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_done: done=1 with no check launched");
                    end else begin
                        e = exp_q.pop_front();
                        if (cyc != e.lat) begin
                            errors++;
                            $display("FAIL latency: got %0d cycles, expected %0d", cyc, e.lat);
                        end
                        checks++;
                        if (pass !== e.pass) begin
                            errors++;
                            $display("FAIL pass: got %0b, expected %0b", pass, e.pass);
                        end
                        checks++;
                        if (timeout !== e.tmo) begin
                            errors++;
                            $display("FAIL timeout: got %0b, expected %0b", timeout, e.tmo);
                        end
                        checks++;
                        if (id_value !== e.id) begin
                            errors++;
                            $display("FAIL id_value: got %h, expected %h", id_value, e.id);
                        end
                        checks++;
                        if (ts_value !== e.ts) begin
                            errors++;
                            $display("FAIL ts_value: got %h, expected %h", ts_value, e.ts);
                        end
                        checks++;
                        if (avm_read !== 1'b0) begin
                            errors++;
                            $display("FAIL read_at_fin: got %0b, expected 0", avm_read);
                        end
                    end
                end
                pbusy = busy;
                pdone = done;
            end
        end
    end

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        int n;
        n = 0;
        while (n < maxc) begin
            @(negedge clock);
            if (done) break;
            n++;
        end
        if (n >= maxc) begin
            checks++;
            errors++;
            $display("FAIL wait_done: no done within %0d cycles", maxc);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0b, expected %0b", name, got, want);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({busy, done, pass, timeout, avm_read, avm_address, id_value, ts_value} !== '0) begin
            errors++;
            $display("FAIL %s: busy=%0b done=%0b pass=%0b tmo=%0b rd=%0b addr=%0b id=%h ts=%h, expected all 0",
                     name, busy, done, pass, timeout, avm_read, avm_address, id_value, ts_value);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        // Reset state, then the single automatic check.
        repeat (2) @(posedge clock);
        #1;
        check_all_zero("reset_state");
        expect_check();
        @(negedge clock);
        reset_n = 1'b1;
        wait_done(40);

        // Timestamp off by one.
        mem1 = ETS + 32'd1;
        expect_check();
        pulse_start();
        wait_done(40);

        // Three wait states on each read.
        mem1 = ETS;
        plan_id = 3; plan_ts = 3;
        expect_check();
        pulse_start();
        wait_done(40);

        // Timestamp read stuck: timeout, ts unchanged.
        mem0 = 32'h0000_00A5;
        plan_id = 0; plan_ts = 100;
        expect_check();
        pulse_start();
        wait_done(40);
        repeat (2) @(negedge clock);
        check_bit("read_after_timeout", avm_read, 1'b0);

        // Start while busy is ignored.
        mem0 = EID; plan_ts = 0;
        expect_check();
        pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done(40);
        // Start during FIN is ignored.
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        check_bit("fin_start_ignored", busy, 1'b0);
        // Start in the IDLE cycle right after FIN is accepted.
        expect_check();
        wait_done(40);
        pulse_start();
        check_bit("done_cleared", done, 1'b0);
        wait_done(40);

        // Randomized checks.
        for (int i = 0; i < 30; i++) begin
            mem0 = ($urandom_range(0, 1) == 1) ? EID : $urandom;
            r = $urandom_range(0, 2);
            if (r == 0) mem1 = ETS;
            else if (r == 1) mem1 = ETS ^ (32'd1 << $urandom_range(0, 31));
            else mem1 = $urandom;
            plan_id = ($urandom_range(0, 7) == 0) ? 6 : $urandom_range(0, 3);
            plan_ts = ($urandom_range(0, 7) == 0) ? 6 : $urandom_range(0, 3);
            expect_check();
            pulse_start();
            wait_done(60);
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end

        // Reset during a stalled ID read, then one automatic check.
        mem0 = EID; mem1 = ETS;
        plan_id = 100; plan_ts = 0;
        expect_check();
        pulse_start();
        @(negedge clock);
        check_bit("read_before_reset", avm_read, 1'b1);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("reset_mid_read");
        exp_q.delete();
        m_id = 32'd0; m_ts = 32'd0;
        plan_id = 0;
        expect_check();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        wait_done(40);

        repeat (6) @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_checks: %0d left, expected 0", exp_q.size());
        end
        check_bit("final_idle", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rlc_game_sysid_check.md
RLC_GAME_SYSID_CHECK -- requirements
Module: rlc_game_sysid_check

Interface
REQ-001 The block SHALL have parameter EXPECTED_ID, default 0, meaning the required 32-bit system ID read from word address 0.
REQ-002 The block SHALL have parameter EXPECTED_TS, default 1495887352, meaning the required 32-bit build timestamp read from word address 1.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum cycles a read may stall on waitrequest; legal range 1..65535.
REQ-004 The block SHALL have parameter AUTO_START, default 1, meaning one check runs automatically on leaving reset.
REQ-005 The block SHALL have ports: clock in 1, the single clock; reset_n in 1, reset (one clock; reset is asynchronous and active-low).
REQ-006 The block SHALL have ports: start in 1, pulse requesting a check; busy out 1, check in progress.
REQ-007 The block SHALL have Avalon-MM master ports: avm_address out 1, word select; avm_read out 1, read strobe; avm_waitrequest in 1, slave stall; avm_readdata in 32, read data.
REQ-008 The block SHALL have ports: done out 1, check finished (sticky); pass out 1, ID and timestamp both match; timeout out 1, a read stalled too long.
REQ-009 The block SHALL have ports: id_value out 32, captured ID; ts_value out 32, captured timestamp.

Function
REQ-010 The FSM SHALL have states IDLE, RD_ID, RD_TS, CHECK, FIN.
REQ-011 IDLE SHALL go to RD_ID when start=1, or on the first cycle after reset when AUTO_START=1; otherwise it SHALL hold.
REQ-012 In RD_ID, the block SHALL drive avm_read=1 and avm_address=0; data SHALL be captured into id_value in the first cycle with avm_waitrequest=0, and the FSM SHALL move to RD_TS.
REQ-013 In RD_TS, the block SHALL drive avm_read=1 and avm_address=1; data SHALL be captured into ts_value in the first cycle with avm_waitrequest=0, and the FSM SHALL move to CHECK.
REQ-014 avm_address and avm_read SHALL be registered outputs and SHALL remain stable while avm_waitrequest=1.
REQ-015 Outside RD_ID and RD_TS, avm_read SHALL be 0 and avm_address SHALL be 0.
REQ-016 A 16-bit stall counter SHALL clear on entry to each read state and increment on each cycle with avm_waitrequest=1.
REQ-017 When the stall counter reaches TIMEOUT_CYCLES, the block SHALL set timeout=1, force pass=0, deassert avm_read on the next cycle, and go to FIN; the captured value for the aborted read SHALL remain unchanged.
REQ-018 CHECK SHALL last one cycle and set pass=1 only if id_value==EXPECTED_ID and ts_value==EXPECTED_TS; it SHALL then go to FIN.
REQ-019 FIN SHALL set done=1 and go to IDLE on the next cycle.
REQ-020 done, pass, timeout, id_value and ts_value SHALL hold until the next check starts.
REQ-021 Entry to RD_ID SHALL clear done, pass and timeout.
REQ-022 busy SHALL be 1 in RD_ID, RD_TS, CHECK and FIN, and 0 in IDLE.
REQ-023 start SHALL be ignored while busy=1.
REQ-024 start asserted in the same cycle as FIN SHALL be ignored; start in the following IDLE cycle SHALL be accepted.
REQ-025 With zero wait states, latency from start sampled high to done=1 SHALL be 4 cycles: RD_ID, RD_TS, CHECK, FIN.

Reset
REQ-026 reset_n=0 SHALL asynchronously force state IDLE and all outputs to 0: busy, done, pass, timeout, avm_read, avm_address, id_value, ts_value.
REQ-027 The stall counter SHALL also reset to 0.
REQ-028 Reset asserted mid-read SHALL drop avm_read immediately, with no completion of the pending transfer.
REQ-029 After reset release with AUTO_START=1, exactly one check SHALL run without start.

Verification
REQ-030 AUTO_START=1, slave returning 0 at addr 0 and 1495887352 at addr 1 with no waitrequest -> after reset release, done=1 and pass=1 on cycle 4; id_value=0; ts_value=1495887352.
REQ-031 Slave returning timestamp 1495887353 -> done=1, pass=0, timeout=0, ts_value=1495887353.
REQ-032 avm_waitrequest held high 3 cycles during each read -> avm_address/avm_read stable throughout; done on cycle 10; pass=1.
REQ-033 TIMEOUT_CYCLES=4, waitrequest stuck high in RD_TS -> timeout=1, pass=0, done=1, avm_read=0 afterwards, ts_value unchanged from the previous check.
REQ-034 start pulsed while busy, then again one cycle after done -> first pulse ignored; second pulse launches exactly one new check, clearing done on RD_ID entry.
REQ-035 reset_n asserted during RD_ID stall -> all outputs 0 in the same cycle; after release, one auto check completes with pass=1.
